// File: rtl/w_stage_pkg.sv
// Shared encodings for the writeback stage and the M-stage decoder.
package w_pkg;

    typedef enum logic [1:0] {
        RSEL_ALU  = 2'b00,
        RSEL_LOAD = 2'b01,
        RSEL_LINK = 2'b10
    } rsel_e;

    // Codes 5..7 are undefined and are handled as a plain word load.
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_e;

endpackage

// File: rtl/w_stage_ld_ext.sv
// Load data extractor: picks a byte/halfword out of the aligned memory word
// using the low address bits and sign- or zero-extends it to DW.
module ld_ext
    import w_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] dm_i,
    input  logic [1:0]    alo_i,
    input  logic [2:0]    ld_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] byte_sh;
    logic [DW-1:0] half_sh;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    // Shift the addressed byte/halfword down to bit 0; alo[0] is ignored for halves.
    always_comb begin
        byte_sh = dm_i >> {alo_i, 3'b000};
        half_sh = dm_i >> {alo_i[1], 4'b0000};
        byte_v  = byte_sh[7:0];
        half_v  = half_sh[15:0];
    end

    // Extend according to load type.
    always_comb begin
        data_o = dm_i;
        case (ld_i)
            LD_B:    data_o = {{(DW-8){byte_v[7]}}, byte_v};
            LD_BU:   data_o = {{(DW-8){1'b0}}, byte_v};
            LD_H:    data_o = {{(DW-16){half_v[15]}}, half_v};
            LD_HU:   data_o = {{(DW-16){1'b0}}, half_v};
            default: data_o = dm_i;
        endcase
    end

endmodule

// File: rtl/w_stage.sv
// Writeback stage: M/W pipeline register with stall/flush, result select,
// GRF write-enable qualification and retired-instruction counter.
// All outputs derive from registered state only.
module w_stage
    import w_pkg::*;
#(
    parameter int DW       = 32,
    parameter int RAW      = 5,
    parameter int LINK_OFF = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_m,
    input  logic [DW-1:0]    alu_m,
    input  logic [DW-1:0]    dm_m,
    input  logic [1:0]       alo_m,
    input  logic [2:0]       ld_m,
    input  logic [DW-1:0]    pc_m,
    input  logic [1:0]       rsel_m,
    input  logic [RAW-1:0]   wa_m,
    input  logic             we_m,
    output logic [DW-1:0]    result_w,
    output logic [RAW-1:0]   wa_w,
    output logic             we_w,
    output logic [DW-1:0]    pc_w,
    output logic             valid_w,
    output logic [CNT_W-1:0] instret
);

    logic             valid_q, valid_d;
    logic [DW-1:0]    alu_q,   alu_d;
    logic [DW-1:0]    dm_q,    dm_d;
    logic [1:0]       alo_q,   alo_d;
    logic [2:0]       ld_q,    ld_d;
    logic [DW-1:0]    pc_q,    pc_d;
    logic [1:0]       rsel_q,  rsel_d;
    logic [RAW-1:0]   wa_q,    wa_d;
    logic             we_q,    we_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic [DW-1:0]    ld_data;

    // Next M/W contents: flush beats en, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        dm_d    = dm_q;
        alo_d   = alo_q;
        ld_d    = ld_q;
        pc_d    = pc_q;
        rsel_d  = rsel_q;
        wa_d    = wa_q;
        we_d    = we_q;
        if (flush) begin
            valid_d = 1'b0;
            alu_d   = '0;
            dm_d    = '0;
            alo_d   = '0;
            ld_d    = '0;
            pc_d    = '0;
            rsel_d  = '0;
            wa_d    = '0;
            we_d    = 1'b0;
        end else if (en) begin
            valid_d = valid_m;
            alu_d   = alu_m;
            dm_d    = dm_m;
            alo_d   = alo_m;
            ld_d    = ld_m;
            pc_d    = pc_m;
            rsel_d  = rsel_m;
            wa_d    = wa_m;
            we_d    = we_m;
        end
    end

    // A valid W instruction retires when it is replaced (flush or advance).
    always_comb begin
        retire    = valid_q & (en | flush);
        instret_d = instret_q + CNT_W'(retire);
    end

    // Pipeline register and counter; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            dm_q      <= '0;
            alo_q     <= '0;
            ld_q      <= '0;
            pc_q      <= '0;
            rsel_q    <= '0;
            wa_q      <= '0;
            we_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            alu_q     <= alu_d;
            dm_q      <= dm_d;
            alo_q     <= alo_d;
            ld_q      <= ld_d;
            pc_q      <= pc_d;
            rsel_q    <= rsel_d;
            wa_q      <= wa_d;
            we_q      <= we_d;
            instret_q <= instret_d;
        end
    end

    ld_ext #(.DW(DW)) u_ld_ext (
        .dm_i   (dm_q),
        .alo_i  (alo_q),
        .ld_i   (ld_q),
        .data_o (ld_data)
    );

    // Writeback result select; the unused encoding yields zero.
    always_comb begin
        result_w = '0;
        case (rsel_q)
            RSEL_ALU:  result_w = alu_q;
            RSEL_LOAD: result_w = ld_data;
            RSEL_LINK: result_w = pc_q + DW'(LINK_OFF);
            default:   result_w = '0;
        endcase
    end

    // Register 0 is hard-wired, so writes to it are never issued.
    always_comb begin
        we_w    = valid_q & we_q & (wa_q != '0);
        wa_w    = wa_q;
        pc_w    = pc_q;
        valid_w = valid_q;
        instret = instret_q;
    end

endmodule

// File: tb/tb_w_stage.sv
module tb_w_stage;
    import w_pkg::*;

    logic        clk = 1'b0;
    logic        reset, en, flush, valid_m, we_m;
    logic [31:0] alu_m, dm_m, pc_m;
    logic [1:0]  alo_m, rsel_m;
    logic [2:0]  ld_m;
    logic [4:0]  wa_m;
    logic [31:0] result_w, pc_w;
    logic [4:0]  wa_w;
    logic        we_w, valid_w;
    logic [31:0] instret;
    logic [31:0] result_w4, pc_w4;
    logic [4:0]  wa_w4;
    logic        we_w4, valid_w4;
    logic [3:0]  instret4;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic exp_valid = 1'b0;

    always #5 clk = ~clk;

    w_stage #(.DW(32), .RAW(5), .LINK_OFF(8), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_m(valid_m),
        .alu_m(alu_m), .dm_m(dm_m), .alo_m(alo_m), .ld_m(ld_m), .pc_m(pc_m),
        .rsel_m(rsel_m), .wa_m(wa_m), .we_m(we_m),
        .result_w(result_w), .wa_w(wa_w), .we_w(we_w), .pc_w(pc_w),
        .valid_w(valid_w), .instret(instret)
    );

    w_stage #(.DW(32), .RAW(5), .LINK_OFF(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_m(valid_m),
        .alu_m(alu_m), .dm_m(dm_m), .alo_m(alo_m), .ld_m(ld_m), .pc_m(pc_m),
        .rsel_m(rsel_m), .wa_m(wa_m), .we_m(we_m),
        .result_w(result_w4), .wa_w(wa_w4), .we_w(we_w4), .pc_w(pc_w4),
        .valid_w(valid_w4), .instret(instret4)
    );

    // Advance one clock; the retirement count is tracked from the stimulus alone.
    task automatic step();
        if (reset) begin
            exp_cnt   = 0;
            exp_valid = 1'b0;
        end else begin
            if (exp_valid && (en || flush)) exp_cnt++;
            if (flush)   exp_valid = 1'b0;
            else if (en) exp_valid = valid_m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] rs, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [1:0] alo, input logic [2:0] ld,
                         input logic [31:0] pc, input logic [4:0] wa, input logic we);
        valid_m = v; rsel_m = rs; alu_m = alu; dm_m = dm; alo_m = alo;
        ld_m = ld; pc_m = pc; wa_m = wa; we_m = we;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0;
        drive(1'b1, RSEL_LINK, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'd3, LD_B, 32'h0000_4000, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({result_w, wa_w, we_w, pc_w, valid_w, instret} !== 103'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: result=%h wa=%0d we=%b pc=%h valid=%b instret=%0d, required all 0",
                         i, result_w, wa_w, we_w, pc_w, valid_w, instret);
            end
            checks++;
            if (instret4 !== 4'd0) begin
                errors++;
                $display("FAIL reset_instret4 got %0d want 0", instret4);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  t_ld [8];
        logic [1:0]  t_alo[8];
        logic [31:0] t_exp[8];
        t_ld[0] = LD_B;  t_alo[0] = 2'd0; t_exp[0] = 32'h0000_007F;
        t_ld[1] = LD_B;  t_alo[1] = 2'd3; t_exp[1] = 32'hFFFF_FF80;
        t_ld[2] = LD_BU; t_alo[2] = 2'd3; t_exp[2] = 32'h0000_0080;
        t_ld[3] = LD_H;  t_alo[3] = 2'd2; t_exp[3] = 32'hFFFF_8001;
        t_ld[4] = LD_HU; t_alo[4] = 2'd0; t_exp[4] = 32'h0000_F07F;
        t_ld[5] = LD_W;  t_alo[5] = 2'd0; t_exp[5] = 32'h8001_F07F;
        t_ld[6] = LD_B;  t_alo[6] = 2'd1; t_exp[6] = 32'hFFFF_FFF0;
        t_ld[7] = 3'd7;  t_alo[7] = 2'd2; t_exp[7] = 32'h8001_F07F;
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, RSEL_LOAD, 32'h5555_5555, 32'h8001_F07F, t_alo[i], t_ld[i], 32'h100, 5'd5, 1'b1);
            step();
            checks++;
            if (result_w !== t_exp[i]) begin
                errors++;
                $display("FAIL load_%0d ld=%0d alo=%0d got %h want %h", i, t_ld[i], t_alo[i], result_w, t_exp[i]);
            end
            checks++;
            if (we_w !== 1'b1 || wa_w !== 5'd5) begin
                errors++;
                $display("FAIL load_we_%0d got we=%b wa=%0d want we=1 wa=5", i, we_w, wa_w);
            end
        end
    endtask

    task automatic test_link();
        en = 1'b1; flush = 1'b0;
        drive(1'b1, RSEL_LINK, 32'h0, 32'h0, 2'd0, LD_W, 32'h0000_3000, 5'd31, 1'b1);
        step();
        checks++;
        if (result_w !== 32'h0000_3008 || we_w !== 1'b1 || wa_w !== 5'd31) begin
            errors++;
            $display("FAIL link_r31 got result=%h we=%b wa=%0d want 00003008 1 31", result_w, we_w, wa_w);
        end
        drive(1'b1, RSEL_LINK, 32'h0, 32'h0, 2'd0, LD_W, 32'h0000_3000, 5'd0, 1'b1);
        step();
        checks++;
        if (result_w !== 32'h0000_3008 || we_w !== 1'b0) begin
            errors++;
            $display("FAIL link_r0 got result=%h we=%b want 00003008 0", result_w, we_w);
        end
        drive(1'b1, 2'b11, 32'h7777_7777, 32'h0, 2'd0, LD_W, 32'h0, 5'd3, 1'b1);
        step();
        checks++;
        if (result_w !== 32'h0) begin
            errors++;
            $display("FAIL rsel_11 got %h want 0", result_w);
        end
    endtask

    task automatic test_stall();
        en = 1'b1; flush = 1'b0;
        drive(1'b1, RSEL_ALU, 32'h0000_1234, 32'h0, 2'd0, LD_W, 32'h0000_0200, 5'd7, 1'b1);
        step();
        checks++;
        if (result_w !== 32'h0000_1234 || instret !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_capture got result=%h instret=%0d want 00001234 %0d", result_w, instret, exp_cnt);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, RSEL_LINK, 32'hAAAA_0000 + 32'(i), 32'h1, 2'd1, LD_B, 32'h9000, 5'd11, 1'b0);
            step();
            checks++;
            if (result_w !== 32'h0000_1234 || wa_w !== 5'd7 || we_w !== 1'b1 ||
                pc_w !== 32'h0000_0200 || valid_w !== 1'b1 || instret !== 32'(exp_cnt)) begin
                errors++;
                $display("FAIL stall_hold_%0d got result=%h wa=%0d we=%b pc=%h valid=%b instret=%0d want 00001234 7 1 00000200 1 %0d",
                         i, result_w, wa_w, we_w, pc_w, valid_w, instret, exp_cnt);
            end
        end
        en = 1'b1;
        drive(1'b0, RSEL_ALU, 32'h0, 32'h0, 2'd0, LD_W, 32'h0, 5'd0, 1'b0);
        step();
        checks++;
        if (instret !== 32'd12 || valid_w !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got instret=%0d valid=%b want 12 0", instret, valid_w);
        end
    endtask

    task automatic test_flush();
        en = 1'b1; flush = 1'b0;
        drive(1'b1, RSEL_ALU, 32'h0000_00AA, 32'h0, 2'd0, LD_W, 32'h300, 5'd4, 1'b1);
        step();
        flush = 1'b1;
        drive(1'b1, RSEL_ALU, 32'h0000_00BB, 32'h0, 2'd0, LD_W, 32'h304, 5'd6, 1'b1);
        step();
        flush = 1'b0;
        checks++;
        if (valid_w !== 1'b0 || we_w !== 1'b0 || instret !== 32'd13) begin
            errors++;
            $display("FAIL flush got valid=%b we=%b instret=%0d want 0 0 13", valid_w, we_w, instret);
        end
        checks++;
        if (instret !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL flush_model got instret=%0d want %0d", instret, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        en = 1'b1; flush = 1'b0;
        drive(1'b1, RSEL_ALU, 32'h0000_0055, 32'h0, 2'd0, LD_W, 32'h400, 5'd2, 1'b1);
        step();
        en = 1'b0; flush = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0;
        checks++;
        if (valid_w !== 1'b0 || result_w !== 32'h0 || instret !== 32'd0 || instret4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_stall got valid=%b result=%h instret=%0d instret4=%0d want 0 0 0 0",
                     valid_w, result_w, instret, instret4);
        end
    endtask

    task automatic test_wrap();
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, RSEL_ALU, 32'(i), 32'h0, 2'd0, LD_W, 32'h0, 5'd1, 1'b1);
            step();
        end
        drive(1'b0, RSEL_ALU, 32'h0, 32'h0, 2'd0, LD_W, 32'h0, 5'd0, 1'b0);
        step();
        checks++;
        if (instret4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cnt4 got %0d want 1", instret4);
        end
        checks++;
        if (instret !== 32'd17) begin
            errors++;
            $display("FAIL wrap_cnt32 got %0d want 17", instret);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0;
        drive(1'b0, RSEL_ALU, 32'h0, 32'h0, 2'd0, LD_W, 32'h0, 5'd0, 1'b0);
        test_reset();
        test_loads();
        test_link();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_stage.md
# w_stage

Parametrised writeback stage for the five-stage pipeline. It owns the M/W pipeline register with stall and flush, and selects the writeback result from the ALU, the load path (with byte/halfword extraction and extension) or the link address. It gates the register-file write enable and keeps a retired-instruction counter. It sits between the data-memory stage and the GRF, replacing the bare W-stage result mux.

## Interface
Parameters:
- DW, 32, datapath width (register, ALU, memory word, PC)
- RAW, 5, register-address width
- LINK_OFF, 8, offset added to the registered PC for link results
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  advance M/W register; 0 = stall (hold)
- flush  in  1  load a bubble into W
- valid_m  in  1  M-stage instruction valid
- alu_m  in  DW  ALU result
- dm_m  in  DW  raw aligned data-memory word
- alo_m  in  2  address bits [1:0] of the load
- ld_m  in  3  load type (LW, LB, LBU, LH, LHU)
- pc_m  in  DW  instruction PC
- rsel_m  in  2  result select (ALU, LOAD, LINK)
- wa_m  in  RAW  destination register
- we_m  in  1  register write request
- result_w  out  DW  writeback data
- wa_w  out  RAW  destination register
- we_w  out  1  GRF write enable (qualified)
- pc_w  out  DW  registered PC
- valid_w  out  1  W holds a real instruction
- instret  out  CNT_W  retired-instruction count

## Operation
- The M/W register holds valid, alu, dm, alo, ld, pc, rsel, wa and we.
- Update priority each rising edge: reset > flush > en > hold.
  - reset: all fields 0.
  - flush: valid=0, we=0; other fields don't-care (implementation clears them).
  - en=1: capture the *_m inputs.
  - en=0: hold.
- Result select, combinational from registered fields:
  - ALU (2'b00): alu.
  - LOAD (2'b01): extended load data.
  - LINK (2'b10): pc + LINK_OFF, truncated mod 2^DW.
  - 2'b11: 0.
- Load extension from dm and alo:
  - LW: word unchanged.
  - LB/LBU: byte alo, sign- or zero-extended to DW.
  - LH/LHU: half selected by alo[1], alo[0] ignored, sign- or zero-extended.
  - Undefined ld codes are treated as LW.
- we_w = valid & we & (wa != 0). A write to register 0 is never issued.
- instret increments by 1 on each cycle where valid_w=1 and the register is being replaced, i.e. (en | flush) and not reset. It wraps at 2^CNT_W. A held (stalled) instruction is counted once only, when it leaves.
- Flush and en both 1: flush wins. The leaving instruction is still counted.

## Timing
- Latency: M inputs to W outputs is 1 cycle. result_w, we_w and wa_w are valid in the cycle after capture.
- No combinational path from any *_m input to any output.
- Reset values: result_w=0, wa_w=0, we_w=0, pc_w=0, valid_w=0, instret=0. Note result_w=0 because rsel=ALU and alu=0.
- Stall: all outputs stable for the whole stall. we_w stays asserted if it was asserted; the GRF rewrites the same value, which is harmless.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.

## Structure
- Shared package w_pkg:
  - rsel encodings: RSEL_ALU, RSEL_LOAD, RSEL_LINK.
  - ld encodings: LD_W, LD_B, LD_BU, LD_H, LD_HU.
  - Reused by the controller and the M-stage decoder.
- Sub-module ld_ext: combinational load extractor/extender (dm, alo, ld -> DW data), parametrised on DW.
- Top: register, select mux, we qualification, counter.

## Test plan
- Reset then idle: all outputs 0 and instret=0 for 3 cycles, regardless of *_m values.
- Loads with dm=0x8001_F07F, rsel=LOAD:
  - LB, alo=0 -> 0x0000_007F.
  - LB, alo=3 -> 0xFFFF_FF80.
  - LBU, alo=3 -> 0x0000_0080.
  - LH, alo=2 -> 0xFFFF_8001.
  - LHU, alo=0 -> 0x0000_F07F.
  - LW -> 0x8001_F07F.
- Link: pc_m=0x0000_3000, rsel=LINK, wa=31, we=1 -> result_w=0x0000_3008 and we_w=1 next cycle. Same with wa=0 -> we_w=0.
- Stall: capture alu=0x1234; hold en=0 for 4 cycles while changing inputs -> outputs constant; instret increments exactly once after en returns.
- Flush with en=1 and a valid M instruction -> next cycle valid_w=0, we_w=0, and instret counts the prior valid W instruction.
- Counter wrap with CNT_W=4: 17 retirements -> instret=1.
